preg_free_list: RTL and testbench
=================================

// Module: preg_free_list
// PURPOSE
//  Owns the 64-entry physical-register free pool used by the dual-issue rename stage.
//  Grants up to two free physical registers per cycle, lowest free index first.
//  Returns registers freed by the two retire ports to the pool.
//  Rename waits on stall_o instead of scanning the pool combinationally itself.
// PARAMETERS
//  NUM_PREG  64  total physical registers
//  NUM_AREG  32  architectural registers; P0..P(NUM_AREG-1) are mapped at reset
//  PREG_W    6   physical register index width, = clog2(NUM_PREG)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  alloc_req_1   in   1       slot-1 rename needs a destination preg
//  alloc_req_2   in   1       slot-2 rename needs a destination preg
//  alloc_gnt_1   out  1       slot-1 grant, combinational this cycle
//  alloc_gnt_2   out  1       slot-2 grant, combinational this cycle
//  alloc_preg_1  out  PREG_W  preg granted to slot 1; 0 when not granted
//  alloc_preg_2  out  PREG_W  preg granted to slot 2; 0 when not granted
//  stall_o       out  1       requests exceed free registers; nothing is granted
//  rel_en_1      in   1       retire port 1 frees rel_preg_1
//  rel_preg_1    in   PREG_W  preg freed by retire port 1
//  rel_en_2      in   1       retire port 2 frees rel_preg_2
//  rel_preg_2    in   PREG_W  preg freed by retire port 2
//  free_cnt_o    out  PREG_W+1  registered count of free pregs
//  dbl_free_o    out  1       sticky error flag; cleared only by reset
// BEHAVIOUR
//  State: bitmap used[NUM_PREG] (1 = allocated), free_cnt, dbl_free. All registered.
//  Reset (async, rst_n=0):
//   - used[0..NUM_AREG-1]=1; all other entries 0.
//   - free_cnt=NUM_PREG-NUM_AREG (32); dbl_free=0.
//   - With no requests pending, all gnt/preg outputs read 0.
//  Grant rules (combinational from the registered bitmap only; same-cycle releases are not bypassed):
//   - nreq = alloc_req_1 + alloc_req_2.
//   - If nreq > free_cnt: stall_o=1, both gnt=0, preg outputs=0. All-or-nothing; never grant a single slot.
//   - Otherwise stall_o=0.
//   - Both slots request: slot 1 gets the lowest free index; slot 2 gets the next lowest free index.
//   - Only slot 2 requests: slot 2 gets the lowest free index.
//   - A requesting slot's gnt=1 in the same cycle.
//   - Granted entries are marked used at the next rising edge.
//  Release rules (applied at the rising edge):
//   - Ignored when rel_preg == 0; P0 is permanently x0.
//   - Release of an entry already free: ignored; sets dbl_free.
//   - Both ports name the same index: freed once; sets dbl_free.
//   - A freed entry is grantable from the following cycle, never the same cycle.
//  Counter:
//   - free_cnt_next = free_cnt - granted + valid_releases.
//   - Range 0..NUM_PREG-NUM_AREG+... in practice; must never wrap.
//   - Assertion: free_cnt equals the popcount of ~used.
//  Same cycle grant and release: both apply. A grant never targets an entry being released (that entry is used).
//  Reset mid-operation: in-flight grants are discarded; bitmap returns to the reset image.
// TESTING
//  1. Release rst_n, no requests -> free_cnt_o=32, gnt=0, stall_o=0, dbl_free_o=0.
//  2. alloc_req_1=1, alloc_req_2=1 -> preg_1=32, preg_2=33 same cycle; free_cnt_o=30 next cycle.
//  3. 16 dual requests drain the pool; next cycle, 1 request -> stall_o=1, gnt=0, free_cnt_o stays 0.
//  4. Pool empty, rel_en_1=1 rel_preg_1=40 with alloc_req_1=1 -> stall that cycle; next cycle preg_1=40.
//  5. Release 40 twice, or both ports=45 -> counted once; dbl_free_o=1 stays set.
//     rel_preg_1=0 -> no change.
//  6. After 10 grants, assert rst_n=0 mid-cycle -> outputs back to reset values immediately; free_cnt_o=32.

Source files
------------

// File: rtl/preg_free_list.sv
// Physical-register free pool for a dual-issue rename stage.
// Grants up to two free pregs per cycle (lowest free index first, slot 1 before
// slot 2) and returns pregs freed by the two retire ports.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alloc_req_1/2              rename slots requesting a destination preg
//   alloc_gnt_1/2              same-cycle grants (combinational)
//   alloc_preg_1/2             granted preg index, 0 when not granted (combinational)
//   stall_o                    requests exceed free pregs; nothing granted (combinational)
//   rel_en_1/2, rel_preg_1/2   retire-port releases, applied at the rising edge
//   free_cnt_o                 registered count of free pregs
//   dbl_free_o                 sticky double-free flag, cleared only by reset
module preg_free_list #(
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned NUM_AREG = 32,
    parameter int unsigned PREG_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req_1,
    input  logic                alloc_req_2,
    output logic                alloc_gnt_1,
    output logic                alloc_gnt_2,
    output logic [PREG_W-1:0]   alloc_preg_1,
    output logic [PREG_W-1:0]   alloc_preg_2,
    output logic                stall_o,
    input  logic                rel_en_1,
    input  logic [PREG_W-1:0]   rel_preg_1,
    input  logic                rel_en_2,
    input  logic [PREG_W-1:0]   rel_preg_2,
    output logic [PREG_W:0]     free_cnt_o,
    output logic                dbl_free_o
);

    localparam int unsigned CNT_W = PREG_W + 1;
    localparam logic [NUM_PREG-1:0] RESET_USED =
        {{(NUM_PREG - NUM_AREG){1'b0}}, {NUM_AREG{1'b1}}};
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(NUM_PREG - NUM_AREG);

    logic [NUM_PREG-1:0] used;
    logic [NUM_PREG-1:0] used_next;
    logic [CNT_W-1:0]    free_cnt;
    logic [CNT_W-1:0]    free_cnt_next;
    logic                dbl_free;
    logic                dbl_free_next;

    logic [PREG_W-1:0]   first_idx;
    logic [PREG_W-1:0]   second_idx;
    logic                first_ok;
    logic                second_ok;
    logic [CNT_W-1:0]    nreq;
    logic [NUM_PREG-1:0] grant_mask;
    logic [NUM_PREG-1:0] rel_mask;
    logic [CNT_W-1:0]    ngrant;
    logic [CNT_W-1:0]    nrel;
    logic                rel1_hit;
    logic                rel2_hit;
    logic                rel1_ok;
    logic                rel2_ok;
    logic                rel_same;

    // Two lowest free indices from the registered bitmap only.
    always_comb begin
        first_idx  = '0;
        second_idx = '0;
        first_ok   = 1'b0;
        second_ok  = 1'b0;
        for (int i = 0; i < NUM_PREG; i++) begin
            if (!used[i]) begin
                if (!first_ok) begin
                    first_ok  = 1'b1;
                    first_idx = PREG_W'(i);
                end else if (!second_ok) begin
                    second_ok  = 1'b1;
                    second_idx = PREG_W'(i);
                end
            end
        end
    end

    // All-or-nothing grant; a lone slot-2 request takes the lowest free index.
    always_comb begin
        nreq         = CNT_W'(alloc_req_1) + CNT_W'(alloc_req_2);
        stall_o      = (nreq > free_cnt);
        alloc_gnt_1  = alloc_req_1 && !stall_o;
        alloc_gnt_2  = alloc_req_2 && !stall_o;
        alloc_preg_1 = '0;
        alloc_preg_2 = '0;
        grant_mask   = '0;
        if (alloc_gnt_1) begin
            alloc_preg_1 = first_idx;
            grant_mask   = grant_mask | (NUM_PREG'(1) << first_idx);
        end
        if (alloc_gnt_2) begin
            alloc_preg_2 = alloc_req_1 ? second_idx : first_idx;
            grant_mask   = grant_mask | (NUM_PREG'(1) << alloc_preg_2);
        end
        ngrant = CNT_W'(alloc_gnt_1) + CNT_W'(alloc_gnt_2);
    end

    // Releases: P0 never freed; an already-free target or a duplicated
    // index across ports flags a double free and is applied at most once.
    always_comb begin
        rel1_hit = rel_en_1 && (rel_preg_1 != '0);
        rel2_hit = rel_en_2 && (rel_preg_2 != '0);
        rel_same = rel1_hit && rel2_hit && (rel_preg_1 == rel_preg_2);
        rel1_ok  = rel1_hit && used[rel_preg_1];
        rel2_ok  = rel2_hit && used[rel_preg_2] && !rel_same;
        rel_mask = '0;
        if (rel1_ok) begin
            rel_mask = rel_mask | (NUM_PREG'(1) << rel_preg_1);
        end
        if (rel2_ok) begin
            rel_mask = rel_mask | (NUM_PREG'(1) << rel_preg_2);
        end
        nrel          = CNT_W'(rel1_ok) + CNT_W'(rel2_ok);
        dbl_free_next = dbl_free
                      || (rel1_hit && !used[rel_preg_1])
                      || (rel2_hit && !used[rel_preg_2])
                      || rel_same;
        // Granted entries are free and released ones are used, so the masks are disjoint.
        used_next     = (used | grant_mask) & ~rel_mask;
        free_cnt_next = free_cnt - ngrant + nrel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used     <= RESET_USED;
            free_cnt <= RESET_CNT;
            dbl_free <= 1'b0;
        end else begin
            used     <= used_next;
            free_cnt <= free_cnt_next;
            dbl_free <= dbl_free_next;
        end
    end

    // Counter must track the bitmap exactly.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (free_cnt == CNT_W'($countones(~used)));
        end
    end

    assign free_cnt_o = free_cnt;
    assign dbl_free_o = dbl_free;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list.
module tb_preg_free_list;

    logic       clk;
    logic       rst_n;
    logic       alloc_req_1;
    logic       alloc_req_2;
    logic       alloc_gnt_1;
    logic       alloc_gnt_2;
    logic [5:0] alloc_preg_1;
    logic [5:0] alloc_preg_2;
    logic       stall_o;
    logic       rel_en_1;
    logic [5:0] rel_preg_1;
    logic       rel_en_2;
    logic [5:0] rel_preg_2;
    logic [6:0] free_cnt_o;
    logic       dbl_free_o;

    int checks = 0;
    int errors = 0;

    preg_free_list dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req_1  (alloc_req_1),
        .alloc_req_2  (alloc_req_2),
        .alloc_gnt_1  (alloc_gnt_1),
        .alloc_gnt_2  (alloc_gnt_2),
        .alloc_preg_1 (alloc_preg_1),
        .alloc_preg_2 (alloc_preg_2),
        .stall_o      (stall_o),
        .rel_en_1     (rel_en_1),
        .rel_preg_1   (rel_preg_1),
        .rel_en_2     (rel_en_2),
        .rel_preg_2   (rel_preg_2),
        .free_cnt_o   (free_cnt_o),
        .dbl_free_o   (dbl_free_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic drive(input logic r1, input logic r2,
                         input logic e1, input int p1,
                         input logic e2, input int p2);
        alloc_req_1 = r1;
        alloc_req_2 = r2;
        rel_en_1    = e1;
        rel_preg_1  = 6'(p1);
        rel_en_2    = e2;
        rel_preg_2  = 6'(p2);
        #1;
    endtask

    task automatic chk_grant(input string tag, input int g1, input int p1,
                             input int g2, input int p2, input int st);
        chk({tag, ".gnt1"},  int'(alloc_gnt_1),  g1);
        chk({tag, ".preg1"}, int'(alloc_preg_1), p1);
        chk({tag, ".gnt2"},  int'(alloc_gnt_2),  g2);
        chk({tag, ".preg2"}, int'(alloc_preg_2), p2);
        chk({tag, ".stall"}, int'(stall_o),      st);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #11;
        rst_n = 1'b1;
        step();

        // Reset state
        chk_grant("reset", 0, 0, 0, 0, 0);
        chk("reset.cnt", int'(free_cnt_o), 32);
        chk("reset.dbl", int'(dbl_free_o), 0);

        // Dual grant: lowest two free indices
        drive(1, 1, 0, 0, 0, 0);
        chk_grant("dual0", 1, 32, 1, 33, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("dual0.cnt", int'(free_cnt_o), 30);

        // Slot 2 alone takes the lowest free index
        drive(0, 1, 0, 0, 0, 0);
        chk_grant("only2", 0, 0, 1, 34, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        chk("only2.cnt", int'(free_cnt_o), 29);
        chk_grant("only1", 1, 35, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("only1.cnt", int'(free_cnt_o), 28);

        // Drain remaining 28 with dual requests
        for (int k = 0; k < 14; k++) begin
            drive(1, 1, 0, 0, 0, 0);
            chk_grant("drain", 1, 36 + 2 * k, 1, 37 + 2 * k, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("drain.cnt", int'(free_cnt_o), 0);

        // Empty pool: single request stalls
        drive(1, 0, 0, 0, 0, 0);
        chk_grant("empty", 0, 0, 0, 0, 1);
        step();
        chk("empty.cnt", int'(free_cnt_o), 0);

        // Release not bypassed to a same-cycle grant
        drive(1, 0, 1, 40, 0, 0);
        chk_grant("nobyp", 0, 0, 0, 0, 1);
        step();
        drive(1, 0, 0, 0, 0, 0);
        chk("nobyp.cnt", int'(free_cnt_o), 1);
        chk_grant("regrant40", 1, 40, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("regrant40.cnt", int'(free_cnt_o), 0);

        // Valid release, then double free of the same entry
        drive(0, 0, 1, 40, 0, 0);
        step();
        chk("rel40.cnt", int'(free_cnt_o), 1);
        chk("rel40.dbl", int'(dbl_free_o), 0);
        drive(0, 0, 1, 40, 0, 0);
        step();
        chk("rel40x2.cnt", int'(free_cnt_o), 1);
        chk("rel40x2.dbl", int'(dbl_free_o), 1);

        // Both ports name 45: freed once
        drive(0, 0, 1, 45, 1, 45);
        step();
        chk("both45.cnt", int'(free_cnt_o), 2);
        chk("both45.dbl", int'(dbl_free_o), 1);

        // P0 release ignored
        drive(0, 0, 1, 0, 0, 0);
        step();
        chk("relp0.cnt", int'(free_cnt_o), 2);

        // Free an architectural preg via port 2; it becomes the lowest free
        drive(0, 0, 0, 0, 1, 5);
        step();
        chk("rel5.cnt", int'(free_cnt_o), 3);
        drive(1, 1, 0, 0, 0, 0);
        chk_grant("dual5", 1, 5, 1, 40, 0);
        step();

        // Grant and release in the same cycle both apply
        drive(1, 0, 0, 0, 1, 50);
        chk("gr_rel.cnt_before", int'(free_cnt_o), 1);
        chk_grant("gr_rel", 1, 45, 0, 0, 0);
        step();
        drive(1, 0, 1, 3, 0, 0);
        chk("gr_rel.cnt", int'(free_cnt_o), 1);
        chk_grant("gr50", 1, 50, 0, 0, 0);
        step();

        // One free preg, two requests: all-or-nothing stall
        drive(1, 1, 0, 0, 0, 0);
        chk("one_left.cnt", int'(free_cnt_o), 1);
        chk_grant("allnone", 0, 0, 0, 0, 1);
        step();
        drive(1, 0, 0, 0, 0, 0);
        chk_grant("gr3", 1, 3, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("gr3.cnt", int'(free_cnt_o), 0);
        chk("sticky.dbl", int'(dbl_free_o), 1);

        // Reset, 10 grants, then reset mid-cycle with a grant in flight
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("rst2.cnt", int'(free_cnt_o), 32);
        chk("rst2.dbl", int'(dbl_free_o), 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 0, 0);
            step();
        end
        chk("ten.cnt", int'(free_cnt_o), 22);
        drive(1, 1, 0, 0, 0, 0);
        chk_grant("ten.next", 1, 42, 1, 43, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst.cnt", int'(free_cnt_o), 32);
        chk("midrst.dbl", int'(dbl_free_o), 0);
        chk_grant("midrst.req", 1, 32, 1, 33, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk_grant("midrst.idle", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk("postrst.cnt", int'(free_cnt_o), 32);
        drive(1, 1, 0, 0, 0, 0);
        chk_grant("postrst", 1, 32, 1, 33, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("postrst.cnt2", int'(free_cnt_o), 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
